// File: rtl/instr_fetch_pkg.sv
// Shared CPU constants and types for the fetch stage and the IF/ID register.
// Holds the NOP/HLT encodings, reset vector, IF/ID field widths and the
// fetch FSM state type, plus the modular PC increment helper.
package instr_fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 16'hF000;
    localparam logic [PC_W-1:0]    DEF_RESET_VEC = 16'h0000;
    localparam logic [3:0]         HLT_OPCODE    = 4'hF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // 16-bit modular increment: 16'hFFFF wraps to 16'h0000.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory bus and IF/ID pipeline outputs of the fetch stage.
// master: fetch side (drives iaddr/im_rd_en and the IF/ID fields, reads instr).
// slave : memory/decode side (returns instr, observes everything else).
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic [PC_W-1:0]    iaddr;
    logic               im_rd_en;
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] instr_ID;
    logic [PC_W-1:0]    pc_ID;
    logic               vld_ID;

    modport master (
        output iaddr, im_rd_en, instr_ID, pc_ID, vld_ID,
        input  instr
    );

    modport slave (
        input  iaddr, im_rd_en, instr_ID, pc_ID, vld_ID,
        output instr
    );

endinterface

// File: rtl/instr_fetch_ifid_reg.sv
// Generic pipeline register carrying instruction, PC+1 and a valid bit.
// Ports: clk/rst, hold (keep contents), flush (inject NOP bubble),
// nxt_instr/nxt_pc (load data), instr/pc/vld (registered outputs).
// Priority: rst > flush > hold > load. Flush and reset clear pc to 0.
module instr_fetch_ifid_reg
    import instr_fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               flush,
    input  logic [INSTR_W-1:0] nxt_instr,
    input  logic [PC_W-1:0]    nxt_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               vld
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr <= NOP_INSTR;
            pc    <= '0;
            vld   <= 1'b0;
        end else if (!hold) begin
            instr <= nxt_instr;
            pc    <= nxt_pc;
            vld   <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives the negedge-flopped IM and
// loads the returned word into IF/ID with PC+1, one instruction per cycle.
// Ports: clk/rst; stall, br_tkn/br_tgt, hlt controls; bus (IM + IF/ID);
// halted status and a 32-bit count of valid instructions delivered to ID.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_VEC = DEF_RESET_VEC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_tkn,
    input  logic [PC_W-1:0] br_tgt,
    input  logic            hlt,
    instr_fetch_if.master   bus,
    output logic            halted,
    output logic [31:0]     fetch_cnt
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ifid_load;
    logic            ifid_flush;
    logic            cnt_inc;

    // The IM samples iaddr at the negedge only when enabled, so gating the
    // enable during stall leaves the previous word in place and the held PC
    // is simply re-read once the stall drops.
    assign bus.iaddr    = pc_q;
    assign bus.im_rd_en = (state_q == RUN) && !stall && !rst;
    assign halted       = (state_q == HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_VEC;
            fetch_cnt <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            if (cnt_inc) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    // Priority below reset: redirect > stall > halt > normal fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        cnt_inc    = 1'b0;

        if (br_tkn) begin
            pc_d       = br_tgt;
            ifid_flush = 1'b1;
            state_d    = RUN;
        end else if (stall) begin
            // hold everything
        end else begin
            case (state_q)
                RUN: begin
                    if (hlt) begin
                        state_d    = HALTED;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_d      = pc_inc(pc_q);
                        ifid_load = 1'b1;
                        cnt_inc   = 1'b1;
                    end
                end
                HALTED: begin
                    // frozen until reset or redirect
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    instr_fetch_ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk       (clk),
        .rst       (rst),
        .hold      (!ifid_load),
        .flush     (ifid_flush),
        .nxt_instr (bus.instr),
        .nxt_pc    (pc_inc(pc_q)),
        .instr     (bus.instr_ID),
        .pc        (bus.pc_ID),
        .vld       (bus.vld_ID)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch with a negedge-flopped IM model.
// Driver applies controls and checks PC/status against a behavioural model;
// a monitor pops expected {instr, pc+1} pairs whenever ID shows a new word.
module tb_instr_fetch;

    localparam logic [15:0] NOP = 16'hF000;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc1;
    } ifid_exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_tkn;
    logic [15:0] br_tgt;
    logic        hlt;
    logic        halted;
    logic [31:0] fetch_cnt;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_tkn    (br_tkn),
        .br_tgt    (br_tgt),
        .hlt       (hlt),
        .bus       (bus),
        .halted    (halted),
        .fetch_cnt (fetch_cnt)
    );

    logic [15:0] mem [0:16383];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: captures mem[iaddr] at negedge when enabled.
    initial bus.instr = 16'h0000;
    always @(negedge clk) begin
        if (bus.im_rd_en === 1'b1) begin
            bus.instr <= mem[bus.iaddr[13:0]];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural view of the fetch stage.
    ifid_exp_t   sb [$];
    logic [15:0] m_pc     = 16'h0000;
    logic        m_halted = 1'b0;
    logic [31:0] m_cnt    = 32'd0;
    logic        m_vld    = 1'b0;
    logic        m_known  = 1'b0;

    task automatic step(input logic r, input logic s, input logic b,
                        input logic [15:0] t, input logic h);
        @(posedge clk);
        #1;
        rst = r; stall = s; br_tkn = b; br_tgt = t; hlt = h;
        #2;
        chk("im_rd_en", {31'd0, bus.im_rd_en}, {31'd0, (!r && !m_halted && !s)});
        if (m_known) begin
            chk("iaddr",     {16'd0, bus.iaddr}, {16'd0, m_pc});
            chk("halted",    {31'd0, halted},    {31'd0, m_halted});
            chk("fetch_cnt", fetch_cnt,          m_cnt);
            chk("vld_ID",    {31'd0, bus.vld_ID}, {31'd0, m_vld});
            if (!m_vld) chk("bubble_instr", {16'd0, bus.instr_ID}, {16'd0, NOP});
        end
        // Effect of the coming posedge.
        if (r) begin
            m_pc = 16'h0000; m_halted = 1'b0; m_cnt = 0; m_vld = 1'b0;
            m_known = 1'b1; sb.delete();
        end else if (b) begin
            m_pc = t; m_halted = 1'b0; m_vld = 1'b0;
        end else if (s || m_halted) begin
            // nothing moves
        end else if (h) begin
            m_halted = 1'b1; m_vld = 1'b0;
        end else begin
            sb.push_back('{instr: mem[m_pc[13:0]], pc1: m_pc + 16'd1});
            m_pc  = m_pc + 16'd1;
            m_cnt = m_cnt + 32'd1;
            m_vld = 1'b1;
        end
    endtask

    // Monitor: a new word in ID is signalled by a valid register whose
    // delivery count moved; otherwise a valid word must be holding.
    initial begin
        ifid_exp_t   e;
        ifid_exp_t   held;
        logic [31:0] last_cnt;
        last_cnt = 0;
        held = '{instr: 16'h0, pc1: 16'h0};
        forever begin
            @(posedge clk);
            #2;
            if (bus.vld_ID === 1'b1) begin
                if (fetch_cnt !== last_cnt) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL sb_underflow: got instr %h pc %h expected none", bus.instr_ID, bus.pc_ID);
                    end else begin
                        e = sb.pop_front();
                        chk("instr_ID", {16'd0, bus.instr_ID}, {16'd0, e.instr});
                        chk("pc_ID",    {16'd0, bus.pc_ID},    {16'd0, e.pc1});
                        held = e;
                    end
                end else begin
                    chk("held_instr", {16'd0, bus.instr_ID}, {16'd0, held.instr});
                    chk("held_pc",    {16'd0, bus.pc_ID},    {16'd0, held.pc1});
                end
            end
            last_cnt = fetch_cnt;
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; br_tkn = 1'b0; br_tgt = 16'h0; hlt = 1'b0;
        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) mem[i] = 16'hA000 + 16'(i);
        mem[16'h40] = 16'h4040;
        mem[14'h3FFF] = 16'hBEEF;

        // Reset, then sequential fetch of 0,1 reaching iaddr=2.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Stall three cycles at iaddr=2, then resume.
        repeat (3) step(0, 1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        // Redirect with simultaneous stall.
        step(0, 1, 1, 16'h0040, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        // Halt at 0x10 and sit there, stall toggling.
        step(0, 0, 1, 16'h0010, 0);
        step(0, 0, 0, 0, 1);
        repeat (6) step(0, 1'($urandom_range(0, 1)), 0, 0, 0);
        // Halt and redirect together: redirect wins.
        step(0, 0, 1, 16'h0020, 1);
        repeat (2) step(0, 0, 0, 0, 0);
        // Halt again, then reset out of HALTED.
        step(0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        // PC wrap from 16'hFFFF.
        step(0, 0, 1, 16'hFFFF, 0);
        repeat (3) step(0, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 15) == 0),
                 16'($urandom),
                 1'($urandom_range(0, 31) == 0));
        end
        step(0, 1, 0, 0, 0);
        @(posedge clk);
        #4;
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the pipelined CPU. Owns the program counter, drives the address and read enable of the negedge-flopped 16K×16 instruction memory (IM), and registers the returned word into the IF/ID pipeline register together with PC+1 and a valid bit. Handles stall, branch/jump redirect with flush, and halt.

## Interface

Parameters:
- RESET_VEC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'hF000, word injected into IF/ID on flush, halt or reset.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- br_tkn  in  1  branch/jump resolved taken: redirect and flush.
- br_tgt  in  16  redirect target PC.
- hlt  in  1  decoder: HLT present in IF/ID (valid).
- instr  in  16  IM read data, updated at negedge when im_rd_en is high.
- iaddr  out  16  IM address (= PC).
- im_rd_en  out  1  IM read enable.
- instr_ID  out  16  IF/ID instruction.
- pc_ID  out  16  IF/ID PC+1 of that instruction.
- vld_ID  out  1  IF/ID valid.
- halted  out  1  fetch stopped by HLT.
- fetch_cnt  out  32  count of valid instructions delivered to ID.

## Operation

- States: RUN, HALTED. Reset → RUN.
- Reset (rst high at posedge): PC=RESET_VEC, instr_ID=NOP_INSTR, pc_ID=0, vld_ID=0, halted=0, fetch_cnt=0, state=RUN. While rst is high, im_rd_en=0.
- iaddr = PC at all times (combinational).
- im_rd_en = (state==RUN) & ~stall & ~rst.
- Priority at each posedge: rst > br_tkn > stall > hlt > normal.
- Normal (RUN, no stall): instr_ID<=instr, pc_ID<=PC+1, vld_ID<=1, PC<=PC+1, fetch_cnt+=1.
- br_tkn (any state except reset): PC<=br_tgt, instr_ID<=NOP_INSTR, vld_ID<=0, state<=RUN, halted<=0; fetch_cnt unchanged. Overrides a simultaneous stall or hlt.
- stall (no br_tkn): PC, IF/ID and fetch_cnt hold. Because im_rd_en=0, IM keeps its previous word; on stall release the held PC is read, so no instruction is lost or duplicated.
- hlt (RUN, no br_tkn, no stall): state<=HALTED, halted<=1, PC holds, instr_ID<=NOP_INSTR, vld_ID<=0.
- HALTED: PC, IF/ID and fetch_cnt frozen; im_rd_en=0. Exits only via rst or br_tkn.
- PC+1 is 16-bit modular: 16'hFFFF+1 = 16'h0000. fetch_cnt wraps modulo 2^32. No range check against IM depth; upper address bits are the IM's concern.

## Timing

- Cycle n: iaddr=A and im_rd_en=1. The IM captures mem[A] at the negedge of n. At the posedge ending n, instr_ID=mem[A] and pc_ID=A+1. Fetch-to-ID latency is one cycle; throughput is one instruction per cycle.
- stall must settle within the high phase, before the negedge, because it gates im_rd_en. br_tkn, br_tgt and hlt are sampled only at posedge.
- After a redirect there is exactly one bubble (vld_ID=0); the target instruction appears in ID the following cycle.
- Reset release: the first valid instruction mem[RESET_VEC] reaches ID one cycle after rst deasserts.

## Structure

- Shared CPU package holds: NOP_INSTR, the HLT opcode, RESET_VEC, and the IF/ID field widths (instruction 16, PC 16).
- A single sub-module, ifid_reg, is natural. It holds instr_ID, pc_ID and vld_ID with hold and flush inputs, and can be reused for later pipeline registers. The PC and state logic stay in instr_fetch.

## Test plan

- Reset: rst high for 2 cycles → iaddr=0, im_rd_en=0, vld_ID=0, instr_ID=16'hF000, fetch_cnt=0. With mem[0]=16'h1234, one cycle after release: instr_ID=16'h1234, pc_ID=1, vld_ID=1.
- Sequential: mem[0..3] = 16'hA000..A003, 4 free-running cycles → pc_ID steps 1,2,3,4 with matching words; fetch_cnt=4.
- Stall: stall for 3 cycles while iaddr=2 → iaddr stays 2, im_rd_en=0, instr_ID=mem[1], pc_ID=2 held. First cycle after release → instr_ID=mem[2], pc_ID=3.
- Redirect: br_tkn with br_tgt=16'h0040, and stall asserted in the same cycle → next cycle iaddr=16'h0040, vld_ID=0, instr_ID=NOP_INSTR. Following cycle → instr_ID=mem[16'h40], pc_ID=16'h0041.
- Halt: hlt at iaddr=16'h0010 → halted=1, im_rd_en=0, iaddr frozen at 16'h0010, vld_ID=0 for 5+ cycles. Repeat with hlt and br_tkn together → redirect taken, halted=0. rst while HALTED → RUN at RESET_VEC.
- Wrap: PC=16'hFFFF fetched → pc_ID=16'h0000, next iaddr=16'h0000.
